// File: rtl/dec_rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The master side drives the requests; the slave side (the arbiter) drives the grant.
interface dec_rr_arbiter_4_if;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       a1;
  logic       a0;
  logic       valid;

  modport master (output en, req, done, input gnt, a1, a0, valid);
  modport slave  (input en, req, done, output gnt, a1, a0, valid);
endinterface

// File: rtl/dec_rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded grant hold time.
// The winner is presented as a one-hot grant and as a 2-bit decoder index.
module dec_rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CW       = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dec_rr_arbiter_4_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   hcnt_q, hcnt_d;
  logic [1:0]      own_q, own_d;
  logic            valid_q, valid_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [3:0]      rem_c;
  logic            release_c;

  // First requester at or after the priority pointer, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hcnt_q  <= '0;
      own_q   <= 2'd0;
      valid_q <= 1'b0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      own_q   <= own_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    own_d     = own_q;
    valid_d   = valid_q;
    rem_c     = bus.req & ~(4'b0001 << own_q);
    release_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != 4'b0000)) begin
          state_d = GRANT;
          own_d   = rr_pick(bus.req, ptr_q);
          hcnt_d  = CW'(1);
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        release_c = !bus.en || bus.done || !bus.req[own_q] || (hcnt_q == CW'(MAX_HOLD));
        if (!release_c) begin
          hcnt_d = hcnt_q + CW'(1);
        end else begin
          // The pointer always moves past the releasing owner, even on a self-regrant.
          ptr_d = own_q + 2'd1;
          if (bus.en && (rem_c != 4'b0000)) begin
            own_d  = rr_pick(rem_c, own_q + 2'd1);
            hcnt_d = CW'(1);
          end else if (bus.en && bus.req[own_q]) begin
            hcnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    gnt_d = valid_d ? (4'b0001 << own_d) : 4'b0000;
  end

  assign bus.gnt   = gnt_q;
  assign bus.a1    = own_q[1];
  assign bus.a0    = own_q[0];
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_dec_rr_arbiter_4.sv
// Testbench for dec_rr_arbiter_4: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_dec_rr_arbiter_4;

  localparam int unsigned MAX_HOLD = 8;
  localparam int unsigned CW       = 4;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  dec_rr_arbiter_4_if bus ();

  dec_rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner/pointer/hold-count kept as plain integers.
  int m_valid;
  int m_own;
  int m_ptr;
  int m_hold;

  function automatic int pick_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return start;
  endfunction

  always @(posedge clk) begin
    logic [3:0] others;
    logic       rel;
    if (rst) begin
      m_valid = 0; m_own = 0; m_ptr = 0; m_hold = 0;
    end else if (m_valid == 0) begin
      if (bus.en && bus.req != 4'b0000) begin
        m_own = pick_from(bus.req, m_ptr); m_valid = 1; m_hold = 1;
      end
    end else begin
      rel = !bus.en || bus.done || !bus.req[m_own] || (m_hold == int'(MAX_HOLD));
      if (!rel) m_hold = m_hold + 1;
      else begin
        m_ptr  = (m_own + 1) % 4;
        others = bus.req;
        others[m_own] = 1'b0;
        if (bus.en && others != 4'b0000) begin
          m_own = pick_from(others, m_ptr); m_hold = 1;
        end else if (bus.en && bus.req[m_own]) m_hold = 1;
        else m_valid = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b0000; bus.done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b0; bus.req = 4'b1111; bus.done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec++;
      if (bus.gnt !== 4'b0000 || {bus.a1, bus.a0} !== 2'b00 || bus.valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold cyc%0d: gnt=%b a=%b%b valid=%b, want 0000/00/0", i, bus.gnt, bus.a1, bus.a0, bus.valid);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (bus.gnt !== 4'b0000 || {bus.a1, bus.a0} !== 2'b00 || bus.valid !== 1'b0) begin
        errs++;
        $display("FAIL idle_en0 cyc%0d: gnt=%b a=%b%b valid=%b, want 0000/00/0", i, bus.gnt, bus.a1, bus.a0, bus.valid);
      end
    end
    bus.en = 1'b1;
    tick();
    vec++;
    if (bus.gnt !== 4'b0001 || {bus.a1, bus.a0} !== 2'b00 || bus.valid !== 1'b1) begin
      errs++;
      $display("FAIL first_grant: gnt=%b a=%b%b valid=%b, want 0001/00/1", bus.gnt, bus.a1, bus.a0, bus.valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    bus.en = 1'b1; bus.req = 4'b1111; bus.done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if (bus.gnt !== exp_seq[i] || bus.valid !== 1'b1) begin
        errs++;
        $display("FAIL rotation step%0d: gnt=%b valid=%b, want %b/1", i, bus.gnt, bus.valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g;
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0011; bus.done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_g = (i < 8) ? 4'b0001 : (i < 16) ? 4'b0010 : 4'b0001;
      vec++;
      if (bus.gnt !== exp_g) begin
        errs++;
        $display("FAIL timeout cyc%0d: gnt=%b, want %b", i, bus.gnt, exp_g);
      end
    end
  endtask

  task automatic test_sole_regrant();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0100; bus.done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      vec++;
      if (bus.gnt !== 4'b0100 || bus.valid !== 1'b1 || {bus.a1, bus.a0} !== 2'b10) begin
        errs++;
        $display("FAIL sole_regrant cyc%0d: gnt=%b valid=%b a=%b%b, want 0100/1/10", i, bus.gnt, bus.valid, bus.a1, bus.a0);
      end
    end
  endtask

  task automatic test_drop();
    logic [3:0] exp_g [5];
    logic [3:0] req_s [5];
    logic       en_s  [5];
    req_s = '{4'b0100, 4'b1001, 4'b1001, 4'b1001, 4'b0000};
    en_s  = '{1'b1,    1'b1,    1'b0,    1'b1,    1'b1};
    exp_g = '{4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    bus.done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req = req_s[i]; bus.en = en_s[i];
      tick();
      vec++;
      if (bus.gnt !== exp_g[i]) begin
        errs++;
        $display("FAIL drop step%0d: gnt=%b, want %b", i, bus.gnt, exp_g[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.en = 1'b1; bus.req = 4'b0100; bus.done = 1'b0;
    tick();
    tick();
    vec++;
    if (bus.gnt !== 4'b0100 || {bus.a1, bus.a0} !== 2'b10) begin
      errs++;
      $display("FAIL mid_reset_pre: gnt=%b a=%b%b, want 0100/10", bus.gnt, bus.a1, bus.a0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (bus.gnt !== 4'b0000 || {bus.a1, bus.a0} !== 2'b00 || bus.valid !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: gnt=%b a=%b%b valid=%b, want 0000/00/0", bus.gnt, bus.a1, bus.a0, bus.valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    logic [3:0] sel;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      bus.en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.done = ($urandom_range(0, 5) == 0);
      tick();
      exp_g = (m_valid != 0) ? (4'b0001 << m_own) : 4'b0000;
      vec++;
      if (bus.gnt !== exp_g || bus.valid !== 1'(m_valid) || {bus.a1, bus.a0} !== 2'(m_own)) begin
        errs++;
        $display("FAIL random cyc%0d: gnt=%b valid=%b a=%b%b, want %b/%0d/%0d", i, bus.gnt, bus.valid, bus.a1, bus.a0, exp_g, m_valid, m_own);
      end
      sel = 4'b0001 << {bus.a1, bus.a0};
      vec++;
      if ($countones(bus.gnt) > 1 || (bus.valid === 1'b1 && bus.gnt !== sel)) begin
        errs++;
        $display("FAIL onehot cyc%0d: gnt=%b valid=%b a=%b%b", i, bus.gnt, bus.valid, bus.a1, bus.a0);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    vec = 0; errs = 0;
    rst = 1'b0; bus.en = 1'b0; bus.req = 4'b0000; bus.done = 1'b0;
    test_reset();
    test_rotation();
    test_timeout();
    test_sole_regrant();
    test_drop();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/dec_rr_arbiter_4.md
# dec_rr_arbiter_4

Four-requester round-robin arbiter that shares one 2-to-4 decoded resource, such as a select line, bus slot or output port. It picks one requester per grant and presents the winner both as a 2-bit index (A1 A0) and as a one-hot grant (D3..D0), so the index drives the existing 2-to-4 decoder and the one-hot bus goes to the requesters. Each grant is held for at most MAX_HOLD cycles, so no requester can starve the others.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one grant may last. Legal range 1..15.
- CW, default 4: hold-counter width. Must satisfy 2^CW > MAX_HOLD.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  arbiter enable. When 0, no grant is issued and any active grant is dropped.
- REQ  in  4  request vector; bit i is requester i.
- DONE  in  1  current owner releases the resource; sampled only while VALID=1.
- GNT  out  4  registered one-hot grant (bit i = D_i); 0000 when idle.
- A1, A0  out  1 each  registered binary index of the owner (decoder select).
- VALID  out  1  registered; 1 while a grant is active.

## Operation
- State: FSM {IDLE, GRANT}, priority pointer PTR[1:0], hold counter HCNT[CW-1:0], owner index OWN[1:0].
- Reset (RST=1 at an edge, which overrides everything else): IDLE, PTR=0, HCNT=0, OWN=0, GNT=0000, A1A0=00, VALID=0.
- Selection function: scan indices PTR, PTR+1, PTR+2, PTR+3 (mod 4) and pick the first i with REQ[i]=1.
- IDLE:
  - If EN=1 and REQ≠0, select winner W, go to GRANT, set OWN=W, HCNT=1.
  - Otherwise stay in IDLE.
- GRANT, release conditions (any one): EN=0, DONE=1, REQ[OWN]=0, or HCNT==MAX_HOLD.
- No release: stay in GRANT, HCNT=HCNT+1, outputs unchanged.
- On release, always set PTR=OWN+1 (mod 4). Then:
  - If EN=1 and the remaining requests (REQ with bit OWN cleared) are nonzero: select a winner with the new PTR and regrant back-to-back, with no idle cycle; set HCNT=1.
  - Else if EN=1 and REQ[OWN]=1 (the only requester left): regrant OWN with HCNT=1.
  - Otherwise go to IDLE with GNT=0000, VALID=0.
- Outputs are a pure function of registered state:
  - GNT = VALID ? (1<<OWN) : 0000.
  - A1A0 = OWN while VALID=1; holds its last value when idle.
- Invariant: GNT is one-hot or zero. GNT never has more than one bit set, on any cycle.

## Timing
- Grant latency: REQ/EN sampled at edge k gives GNT/VALID valid after edge k, so the requester sees the grant one cycle later.
- Release latency: DONE, REQ drop or EN=0 sampled at edge k changes GNT after edge k, either to the new owner or to 0000.
- Maximum continuous hold: MAX_HOLD cycles. On the MAX_HOLD-th grant cycle the next edge forces rotation.
- Simultaneous DONE and timeout: a single release, with PTR advanced once.
- EN=0 mid-grant: GNT=0000 after the next edge, and PTR advances past the dropped owner.
- RST mid-grant: all registers take reset values at that edge, and GNT=0000 the following cycle.
- Wrap-around: OWN=3 releases, so PTR=0.

## Test plan
- Reset and idle: RST=1 for 2 cycles with REQ=1111, then RST=0 and EN=0 → GNT=0000, A1A0=00, VALID=0 throughout. With EN=1, one cycle later → GNT=0001, A1A0=00.
- Round-robin rotation: EN=1, REQ=1111, pulse DONE once per grant → grant order 0001, 0010, 0100, 1000, 0001, with no idle cycles between grants.
- Timeout: MAX_HOLD=8, REQ=0011, DONE=0 → GNT=0001 for exactly 8 cycles, then 0010 for 8 cycles, then 0001.
- Sole requester regrant: REQ=0100, DONE held 1 → GNT=0100 continuously with VALID=1; HCNT restarts each cycle, so no gap appears.
- Request drop and EN drop: owner 2 drops REQ → next edge GNT switches to the next pending requester, or 0000 if none. EN=0 while GNT=1000 → GNT=0000 next cycle; EN=1 with REQ=1001 → GNT=0001 (PTR wrapped to 0).
- Mid-grant reset plus continuous check: RST=1 while GNT=0100 → GNT=0000, A1A0=00 next cycle. Across all scenarios, assert every cycle that GNT is one-hot or zero and that GNT==1<<{A1,A0} whenever VALID=1.
